// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation core.
//   state_t             : top-level FSM states (IDLE, CHECK, MUL, SQR, FIN)
//   MODMUL_OVERHEAD     : cycles per modmul beyond the WIDTH iterations
//                         (one go/load cycle plus one capture cycle)
//   modmul_cycles(w)    : cycles per modmul for width w (w + 2)
//   rsa_latency(w)      : start-to-done latency for valid operands
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_MUL   = 3'd2,
    ST_SQR   = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam int MODMUL_OVERHEAD = 2;

  function automatic int modmul_cycles(input int w);
    return w + MODMUL_OVERHEAD;
  endfunction

  // CHECK + FIN, plus one MUL and one SQR modmul for every key bit.
  function automatic int rsa_latency(input int w);
    return 2 + 2 * w * modmul_cycles(w);
  endfunction

endpackage

// File: rtl/rsa_modexp_core_if.sv
// Request/response bundle of the RSA modular-exponentiation core.
//   start  : request, only sampled while the core is idle
//   key    : exponent, data : base, n : modulus (latched on accept)
//   busy   : operation in progress
//   done   : one-cycle completion pulse
//   err    : operand error, valid with done
//   result : data^key mod n, valid with done
// master : requester side, slave : core side.
interface rsa_modexp_core_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] key;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] n;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  modport master (
    output start, key, data, n,
    input  busy, done, err, result
  );

  modport slave (
    input  start, key, data, n,
    output busy, done, err, result
  );
endinterface

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier: p = a * b mod n.
// Takes exactly WIDTH + 2 cycles from the cycle go is high to the cycle
// done is high: one load cycle, WIDTH iterations, then done/p are presented.
//   clk, rst_n : clock, asynchronous active-low reset
//   go         : one-cycle start pulse, latches a, b, n
//   a, b, n    : operands; a and b must already be reduced below n
//   done       : one-cycle pulse, p valid in the same cycle
//   p          : product, held until the next go
module rsa_modmul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic             run_reg;
  logic             done_reg;

  // One iteration: 2*acc + (b_msb ? a : 0). With acc, a < n the sum is
  // below 3n, so it fits in WIDTH+2 bits and two conditional subtractions
  // bring it back below n.
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] sub1;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    sum  = {1'b0, acc_reg, 1'b0} + (b_reg[WIDTH-1] ? {2'b00, a_reg} : '0);
    sub1 = (sum >= {2'b00, n_reg}) ? sum - {2'b00, n_reg} : sum;
    acc_next = (sub1 >= {2'b00, n_reg}) ? WIDTH'(sub1 - {2'b00, n_reg})
                                        : WIDTH'(sub1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      n_reg    <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
      run_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (go) begin
        a_reg   <= a;
        b_reg   <= b;
        n_reg   <= n;
        acc_reg <= '0;
        cnt_reg <= CW'(WIDTH);
        run_reg <= 1'b1;
      end else if (run_reg) begin
        acc_reg <= acc_next;
        b_reg   <= {b_reg[WIDTH-2:0], 1'b0};
        cnt_reg <= cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          run_reg  <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done = done_reg;
  assign p    = acc_reg;

endmodule

// File: rtl/rsa_modexp_core.sv
// Constant-time RSA modular exponentiation: result = data^key mod n.
// Right-to-left square-and-multiply over all WIDTH key bits; the multiply
// is always performed and only its write-back depends on the key bit, so
// the latency does not depend on key or data.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : request/response bundle (slave side), see rsa_modexp_core_if
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  rsa_modexp_core_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_reg;
  logic [WIDTH-1:0] key_reg;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] base_reg;
  logic [CW-1:0]    i_reg;
  logic             go_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;
  logic [WIDTH-1:0] result_reg;

  logic             mm_done;
  logic [WIDTH-1:0] mm_p;
  logic [WIDTH-1:0] mm_a;

  // The single multiplier is shared: acc*base in MUL, base*base in SQR.
  assign mm_a = (state_reg == ST_SQR) ? base_reg : acc_reg;

  rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go_reg),
    .a     (mm_a),
    .b     (base_reg),
    .n     (n_reg),
    .done  (mm_done),
    .p     (mm_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      key_reg    <= '0;
      data_reg   <= '0;
      n_reg      <= '0;
      acc_reg    <= '0;
      base_reg   <= '0;
      i_reg      <= '0;
      go_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      go_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            key_reg    <= bus.key;
            data_reg   <= bus.data;
            n_reg      <= bus.n;
            err_reg    <= 1'b0;
            result_reg <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          // Reduced operands are required by the multiplier, so data >= n
          // is rejected rather than pre-reduced.
          if (n_reg < WIDTH'(2) || data_reg >= n_reg) begin
            err_reg    <= 1'b1;
            result_reg <= '0;
            done_reg   <= 1'b1;
            state_reg  <= ST_FIN;
          end else begin
            acc_reg   <= WIDTH'(1);
            base_reg  <= data_reg;
            i_reg     <= '0;
            go_reg    <= 1'b1;
            state_reg <= ST_MUL;
          end
        end

        ST_MUL: begin
          if (mm_done) begin
            if (key_reg[i_reg]) begin
              acc_reg <= mm_p;
            end
            go_reg    <= 1'b1;
            state_reg <= ST_SQR;
          end
        end

        ST_SQR: begin
          if (mm_done) begin
            base_reg <= mm_p;
            if (i_reg == CW'(WIDTH - 1)) begin
              // acc already holds the final value; the last square is
              // still performed to keep every bit the same length.
              result_reg <= acc_reg;
              done_reg   <= 1'b1;
              state_reg  <= ST_FIN;
            end else begin
              i_reg     <= i_reg + CW'(1);
              go_reg    <= 1'b1;
              state_reg <= ST_MUL;
            end
          end
        end

        ST_FIN: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.err    = err_reg;
  assign bus.result = result_reg;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Bench for rsa_modexp_core at WIDTH=8 and WIDTH=16. Expected results are
// queued when a request is driven and popped when done is observed.
module tb_rsa_modexp_core;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rsa_modexp_core_if #(.WIDTH(8))  bus8 ();
  rsa_modexp_core_if #(.WIDTH(16)) bus16 ();

  rsa_modexp_core #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  rsa_modexp_core #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  typedef struct {
    string       tag;
    logic [63:0] result;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input bit w16);
    return w16 ? bus16.done : bus8.done;
  endfunction

  function automatic logic get_busy(input bit w16);
    return w16 ? bus16.busy : bus8.busy;
  endfunction

  function automatic logic get_err(input bit w16);
    return w16 ? bus16.err : bus8.err;
  endfunction

  function automatic logic [63:0] get_result(input bit w16);
    return w16 ? 64'(bus16.result) : 64'(bus8.result);
  endfunction

  task automatic drive_start(input bit w16, input logic [63:0] nn,
                             input logic [63:0] dd, input logic [63:0] kk);
    if (w16) begin
      bus16.n = nn[15:0]; bus16.data = dd[15:0]; bus16.key = kk[15:0];
      bus16.start = 1'b1;
    end else begin
      bus8.n = nn[7:0]; bus8.data = dd[7:0]; bus8.key = kk[7:0];
      bus8.start = 1'b1;
    end
  endtask

  // One request: push the expectation, pulse start, wait (bounded) for done,
  // then pop and compare. poke drives start pulses while busy.
  task automatic run_op(input string tag, input bit w16, input logic [63:0] nn,
                        input logic [63:0] dd, input logic [63:0] kk,
                        input logic [63:0] exp_res, input logic exp_err,
                        input int exp_lat, input bit poke);
    exp_t e;
    int   cyc;
    int   extra_done;
    e.tag = tag; e.result = exp_res; e.err = exp_err; e.lat = exp_lat;
    exp_q.push_back(e);
    @(negedge clk);
    drive_start(w16, nn, dd, kk);
    @(negedge clk);
    bus8.start = 1'b0;
    bus16.start = 1'b0;
    cyc = 1;
    chk({tag, " busy_c1"}, 64'(get_busy(w16)), 64'd1);
    while (!get_done(w16) && cyc < exp_lat + 50) begin
      if (poke && (cyc % 37 == 5)) drive_start(w16, 64'd0, 64'd0, 64'd0);
      @(negedge clk);
      bus8.start = 1'b0;
      bus16.start = 1'b0;
      cyc++;
    end
    e = exp_q.pop_front();
    if (!get_done(w16)) begin
      chk({e.tag, " timeout"}, 64'(cyc), 64'(e.lat));
      return;
    end
    $display("txn %s: n=%0d data=%0d key=%0d result=%0d err=%0d lat=%0d",
             e.tag, nn, dd, kk, get_result(w16), get_err(w16), cyc);
    chk({e.tag, " result"}, get_result(w16), e.result);
    chk({e.tag, " err"}, 64'(get_err(w16)), 64'(e.err));
    chk({e.tag, " latency"}, 64'(cyc), 64'(e.lat));
    chk({e.tag, " busy_at_done"}, 64'(get_busy(w16)), 64'd1);
    @(negedge clk);
    chk({e.tag, " done_pulse"}, 64'(get_done(w16)), 64'd0);
    chk({e.tag, " busy_fall"}, 64'(get_busy(w16)), 64'd0);
    chk({e.tag, " result_hold"}, get_result(w16), e.result);
    if (poke) begin
      extra_done = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (get_done(w16) || get_busy(w16)) extra_done++;
      end
      chk({e.tag, " no_queued_start"}, 64'(extra_done), 64'd0);
    end
  endtask

  initial begin
    int cyc;
    int seen_done;
    n_cmp = 0;
    n_bad = 0;
    bus8.start = 1'b0; bus8.key = '0; bus8.data = '0; bus8.n = '0;
    bus16.start = 1'b0; bus16.key = '0; bus16.data = '0; bus16.n = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst8 busy", 64'(bus8.busy), 64'd0);
    chk("rst8 done", 64'(bus8.done), 64'd0);
    chk("rst8 err", 64'(bus8.err), 64'd0);
    chk("rst8 result", 64'(bus8.result), 64'd0);
    chk("rst16 result", 64'(bus16.result), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("w8_33_4_7",   1'b0, 33, 4, 7,   16, 1'b0, 162, 1'b0);
    run_op("w8_33_16_3",  1'b0, 33, 16, 3,  4,  1'b0, 162, 1'b0);
    run_op("w8_97_4_13",  1'b0, 97, 4, 13,  93, 1'b0, 162, 1'b0);
    run_op("w8_97_4_1",   1'b0, 97, 4, 1,   4,  1'b0, 162, 1'b0);
    run_op("err_n1",      1'b0, 1, 0, 3,    0,  1'b1, 2,   1'b0);
    run_op("after_err1",  1'b0, 97, 4, 1,   4,  1'b0, 162, 1'b0);
    run_op("err_d_ge_n",  1'b0, 33, 40, 3,  0,  1'b1, 2,   1'b0);
    run_op("after_err2",  1'b0, 33, 4, 7,   16, 1'b0, 162, 1'b0);
    run_op("k0",          1'b0, 7, 5, 0,    1,  1'b0, 162, 1'b0);
    run_op("zero_pow0",   1'b0, 7, 0, 0,    1,  1'b0, 162, 1'b0);
    run_op("zero_pow5",   1'b0, 7, 0, 5,    0,  1'b0, 162, 1'b0);
    run_op("w16_max",     1'b1, 65521, 65520, 65535, 65520, 1'b0, 578, 1'b1);

    // Mid-operation reset: outputs clear without waiting for a clock edge.
    @(negedge clk);
    drive_start(1'b0, 64'd33, 64'd4, 64'd7);
    @(negedge clk);
    bus8.start = 1'b0;
    cyc = 1;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst busy_before", 64'(bus8.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(bus8.busy), 64'd0);
    chk("midrst done", 64'(bus8.done), 64'd0);
    chk("midrst err", 64'(bus8.err), 64'd0);
    chk("midrst result", 64'(bus8.result), 64'd0);
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus8.done) seen_done++;
    end
    rst_n = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) seen_done++;
    end
    chk("midrst no_done", 64'(seen_done), 64'd0);
    run_op("post_rst",    1'b0, 33, 4, 7,   16, 1'b0, 162, 1'b0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
